// File: rtl/wrr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wrr_pkg
// Brief   : Shared types and helpers for the weighted round-robin arbiter.
//           Holds the two-state FSM encoding and the grant_id width helper.
// Revision: 1.0 - initial release
// ============================================================================
package wrr_pkg;

  // Arbiter FSM: IDLE waits for any request, GRANT owns one channel.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } wrr_state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage : wrr_pkg
`default_nettype wire

// File: rtl/wrr_rr_picker.sv
`default_nettype none
// ============================================================================
// Module  : wrr_rr_picker
// Brief   : Combinational rotating-priority selector. Returns the first
//           requesting channel at or after ptr+1, wrapping modulo CHANNELS.
// Revision: 1.0 - initial release
// ============================================================================
module wrr_rr_picker
  import wrr_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int ID_W     = id_width(CHANNELS)
)(
  input  logic [CHANNELS-1:0] request,
  input  logic [ID_W-1:0]     ptr,
  output logic [ID_W-1:0]     sel_id,
  output logic                sel_valid
);

  // Scan from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    int idx;
    idx       = 0;
    sel_id    = '0;
    sel_valid = 1'b0;
    for (int k = CHANNELS; k >= 1; k--) begin
      idx = (int'(ptr) + k) % CHANNELS;
      if (request[idx]) begin
        sel_id    = ID_W'(idx);
        sel_valid = 1'b1;
      end
    end
  end

endmodule : wrr_rr_picker
`default_nettype wire

// File: rtl/param_wrr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : param_wrr_arbiter
// Brief   : Weighted round-robin arbiter. A granted channel keeps the grant
//           for up to weight[ch] acknowledged transfers, or until it drops
//           its request; every release is followed by one idle cycle.
//           Optional feature macro: WRR_LOCK_EN adds a 'lock' input that
//           pins the credit at 1 and suppresses the credit-exhaustion release.
// Revision: 1.0 - initial release
// ============================================================================
module param_wrr_arbiter
  import wrr_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int WEIGHT_W = 32,
  localparam int ID_W    = id_width(CHANNELS)
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          request,
  input  logic [CHANNELS*WEIGHT_W-1:0] weight,
  input  logic                         ack,
`ifdef WRR_LOCK_EN
  input  logic                         lock,
`endif
  output logic [CHANNELS-1:0]          grant,
  output logic                         grant_valid,
  output logic [ID_W-1:0]              grant_id,
  output logic [WEIGHT_W-1:0]          credit
);

  localparam logic [WEIGHT_W-1:0] CREDIT_ONE = WEIGHT_W'(1);
  localparam logic [ID_W-1:0]     PTR_RESET  = ID_W'(CHANNELS - 1);

  wrr_state_t          state;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     owner_id;
  logic [WEIGHT_W-1:0] credit_cnt;

  logic [WEIGHT_W-1:0] weight_arr [CHANNELS];
  logic [ID_W-1:0]     sel_id;
  logic                sel_valid;
  logic [WEIGHT_W-1:0] sel_weight;
  logic [WEIGHT_W-1:0] load_credit;
  logic                owner_req;
  logic                drop_release;
  logic                ack_hit;
  logic                lock_hold;
  logic                credit_release;
  logic                release_now;

  // Unpack the flat weight bus into one word per channel.
  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_weight_unpack
      assign weight_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
    end
  endgenerate

  wrr_rr_picker #(
    .CHANNELS (CHANNELS),
    .ID_W     (ID_W)
  ) u_picker (
    .request   (request),
    .ptr       (ptr),
    .sel_id    (sel_id),
    .sel_valid (sel_valid)
  );

`ifdef WRR_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  // Release decisions and the credit to load for a fresh grant.
  always_comb begin
    sel_weight     = weight_arr[sel_id];
    // A zero weight still buys one transfer so the channel is not starved.
    load_credit    = (sel_weight == '0) ? CREDIT_ONE : sel_weight;
    owner_req      = request[owner_id];
    // A dropped request wins over any ack seen in the same cycle.
    drop_release   = (state == GRANT) && !owner_req;
    ack_hit        = (state == GRANT) && owner_req && ack;
    credit_release = ack_hit && !lock_hold && (credit_cnt == CREDIT_ONE);
    release_now    = drop_release || credit_release;
  end

  // FSM, rotation pointer, owner index and credit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= PTR_RESET;
      owner_id   <= '0;
      credit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // ack is meaningless here; only a new selection moves the FSM.
          if (sel_valid) begin
            state      <= GRANT;
            owner_id   <= sel_id;
            credit_cnt <= load_credit;
          end
        end
        GRANT: begin
          if (release_now) begin
            // Rotation resumes after the channel that just finished.
            state      <= IDLE;
            ptr        <= owner_id;
            owner_id   <= '0;
            credit_cnt <= '0;
          end else if (ack_hit && (credit_cnt != CREDIT_ONE)) begin
            // With lock held the count parks at one instead of reaching zero.
            credit_cnt <= credit_cnt - CREDIT_ONE;
          end
        end
        default: begin
          state      <= IDLE;
          owner_id   <= '0;
          credit_cnt <= '0;
        end
      endcase
    end
  end

  // Outputs are all derived from registered state; idle forces zeros.
  always_comb begin
    grant       = '0;
    grant_valid = (state == GRANT);
    grant_id    = owner_id;
    credit      = credit_cnt;
    if (state == GRANT) begin
      grant[owner_id] = 1'b1;
    end
  end

endmodule : param_wrr_arbiter
`default_nettype wire

// File: doc/param_wrr_arbiter.md
PARAM_WRR_ARBITER -- requirements
Module: param_wrr_arbiter

Interface
REQ-001 Parameter CHANNELS, default 8: number of requesters, legal range 2..32.
REQ-002 Parameter WEIGHT_W, default 32: bit width of each channel weight, legal range 1..32.
REQ-003 Port clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset; the block is in reset while reset=0.
REQ-005 Port request, input, CHANNELS: per-channel request; bit i is channel i.
REQ-006 Port weight, input, CHANNELS*WEIGHT_W: packed weights; channel i occupies bits [i*WEIGHT_W +: WEIGHT_W].
REQ-007 Port ack, input, 1: the granted channel consumed one transfer this cycle.
REQ-008 Port grant, output, CHANNELS: one-hot grant, or all-zero when idle.
REQ-009 Port grant_valid, output, 1: OR of grant.
REQ-010 Port grant_id, output, max(1,$clog2(CHANNELS)): index of the granted channel; 0 when grant_valid=0.
REQ-011 Port credit, output, WEIGHT_W: remaining transfers in the current grant; 0 when idle.

Function
REQ-012 The FSM SHALL have two states: IDLE and GRANT.
REQ-013 In IDLE with any request bit set, the block SHALL select the first requesting channel at or after ptr+1 (mod CHANNELS) and SHALL enter GRANT on the next edge, giving 1-cycle request-to-grant latency.
REQ-014 On entering GRANT, credit SHALL load weight[sel], with a weight of 0 loaded as 1; weight is sampled only at this load.
REQ-015 In GRANT, ack=1 SHALL decrement credit by 1.
REQ-016 In GRANT, ack=1 with credit=1 SHALL release the grant: ptr becomes grant_id, the FSM returns to IDLE, and grant becomes 0 on the next edge.
REQ-017 In GRANT, request[grant_id]=0 SHALL release the grant on the next edge whatever the credit value; an ack in that same cycle is ignored.
REQ-018 Every release SHALL be followed by exactly one idle cycle (grant=0) before the next grant.
REQ-019 ack in IDLE SHALL be ignored.
REQ-020 Request changes on non-granted channels SHALL NOT affect the current grant.
REQ-021 At most one grant bit SHALL ever be set.
REQ-022 A channel requesting continuously SHALL be granted within CHANNELS grant periods.

Reset
REQ-023 While reset=0, the outputs SHALL be grant=0, grant_valid=0, grant_id=0, credit=0; the state SHALL be IDLE and ptr SHALL be CHANNELS-1, so channel 0 has first priority.
REQ-024 Reset asserted mid-grant SHALL clear all state immediately, without waiting for a clock edge.
REQ-025 After reset deasserts, the first arbitration SHALL occur on the first rising edge that has reset=1.

Configuration
REQ-026 When the macro WRR_LOCK_EN is defined, the block SHALL add an input port lock, width 1.
REQ-027 With WRR_LOCK_EN defined, lock=1 in GRANT SHALL block the credit-exhaustion release and SHALL hold credit at 1 instead of decrementing it to 0; release by a dropped request still applies.
REQ-028 Without WRR_LOCK_EN, the lock port SHALL NOT exist and the behaviour SHALL be exactly that of REQ-012..REQ-022.

Structure
REQ-029 Package wrr_pkg SHALL hold the FSM state enum (IDLE, GRANT) and the helper function that computes the grant_id width.
REQ-030 The rotating-priority selection SHALL be a combinational sub-module wrr_rr_picker (inputs: request, ptr; outputs: sel_id, sel_valid); all registers SHALL be in param_wrr_arbiter.

Verification (CHANNELS=8, WEIGHT_W=32, weights ch0..ch7 = 3,5,7,9,11,13,15,17)
REQ-031 Reset release, then request=0x08 with ack held at 1: grant=0x08 one cycle later, credit reads 9..1, then grant=0 after 9 acks.
REQ-032 Request=0x91 held, ack=1: grants run ch0 (3 acks), idle cycle, ch4 (11 acks), idle cycle, ch7 (17 acks), idle cycle, then ch0 again.
REQ-033 Request=0x02 granted with credit=5; after 2 acks, request drops to 0x00: grant=0 on the next edge and ptr=1.
REQ-034 Weight ch3=0 and request=0x08: grant holds for exactly 1 ack, then releases.
REQ-035 Reset=0 driven asynchronously mid-grant (between edges): grant and credit go to 0 immediately; after reset release with request=0xFF, channel 0 is granted first.
REQ-036 WRR_LOCK_EN defined, ch1 granted, lock=1, ack=1 for 20 cycles: grant stays 0x02 with credit=1; lock=0 then 1 ack: release.
